acl2_sequencer: RTL and testbench

Sequences all register traffic to the ADXL362 accelerometer on the ACL2 Pmod through a byte-oriented SPI transaction engine. After reset it performs the bring-up sequence: soft reset, wait, DEVID check, filter and power configuration. It then polls STATUS at a fixed rate and, when DATA_READY is set, reads XDATA, YDATA and ZDATA. It publishes the three axes as one coherent, validated sample. It sits between the SPI transaction engine and the display/consumer logic.

---
 rtl/acl2_pkg.sv | 74 +++++++
 rtl/acl2_txn_timer.sv | 28 ++
 rtl/acl2_sequencer.sv | 161 ++++++++++++++++
 tb/tb_acl2_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acl2_pkg.sv
// Shared definitions for the ADXL362 (Pmod ACL2) register sequencer: register map,
// SPI command bytes, fault codes, sequencer states and per-state transaction lookup.
package acl2_pkg;

    localparam logic [7:0] REG_DEVID      = 8'h00;
    localparam logic [7:0] REG_XDATA      = 8'h08;
    localparam logic [7:0] REG_YDATA      = 8'h09;
    localparam logic [7:0] REG_ZDATA      = 8'h0A;
    localparam logic [7:0] REG_STATUS     = 8'h0B;
    localparam logic [7:0] REG_SOFT_RESET = 8'h1F;
    localparam logic [7:0] REG_FILTER_CTL = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] CMD_WRITE      = 8'h0A;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
    localparam logic [7:0] MEASURE_MODE   = 8'h02;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_DEVID   = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_t;

    typedef enum logic [3:0] {
        S_SOFTRST,
        S_RSTWAIT,
        S_IDRD,
        S_FILT,
        S_PWR,
        S_POLLWAIT,
        S_STAT,
        S_RDX,
        S_RDY,
        S_RDZ,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_txn_state(input state_t s);
        return s inside {S_SOFTRST, S_IDRD, S_FILT, S_PWR, S_STAT, S_RDX, S_RDY, S_RDZ};
    endfunction

    // The single register access each transaction state performs.
    function automatic txn_req_t txn_for_state(input state_t s, input logic [7:0] filter_cfg);
        txn_req_t r;
        r = '{cmd: CMD_READ, addr: REG_DEVID, wdata: 8'h00};
        case (s)
            S_SOFTRST: r = '{cmd: CMD_WRITE, addr: REG_SOFT_RESET, wdata: SOFT_RESET_KEY};
            S_IDRD:    r.addr = REG_DEVID;
            S_FILT:    r = '{cmd: CMD_WRITE, addr: REG_FILTER_CTL, wdata: filter_cfg};
            S_PWR:     r = '{cmd: CMD_WRITE, addr: REG_POWER_CTL, wdata: MEASURE_MODE};
            S_STAT:    r.addr = REG_STATUS;
            S_RDX:     r.addr = REG_XDATA;
            S_RDY:     r.addr = REG_YDATA;
            S_RDZ:     r.addr = REG_ZDATA;
            default:   ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/acl2_txn_timer.sv
// Loadable down-counter shared by the reset wait, the poll interval and the
// transaction timeout; tc is high while the count sits at zero.
module acl2_txn_timer #(
    parameter int WIDTH = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/acl2_sequencer.sv
// Drives the ADXL362 bring-up and STATUS-polled X/Y/Z readout through a byte-wide
// SPI transaction engine, publishing each sample as one coherent update.
module acl2_sequencer
    import acl2_pkg::*;
#(
    parameter int         POLL_DIVIDE = 100000,
    parameter int         RESET_WAIT  = 50000,
    parameter int         TIMEOUT     = 200000,
    parameter logic [7:0] ID_EXPECT   = 8'hAD,
    parameter logic [7:0] FILTER_CFG  = 8'h13
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       TXN_START,
    output logic       TXN_RW,
    output logic [7:0] TXN_ADDR,
    output logic [7:0] TXN_WDATA,
    input  logic       TXN_BUSY,
    input  logic       TXN_DONE,
    input  logic [7:0] TXN_RDATA,
    output logic [7:0] X_DATA,
    output logic [7:0] Y_DATA,
    output logic [7:0] Z_DATA,
    output logic       SAMPLE_VALID,
    output logic       INIT_DONE,
    output logic [1:0] FAULT
);

    localparam int CNT_W = $clog2(max3(POLL_DIVIDE, RESET_WAIT, TIMEOUT) + 1);

    // Loads are one less than the interval because the load edge itself counts as a cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RSTWAIT_LOAD = CNT_W'(RESET_WAIT - 1);
    localparam logic [CNT_W-1:0] POLL_LOAD    = CNT_W'(POLL_DIVIDE - 1);

    state_t           state;
    logic             txn_out;
    txn_req_t         req;
    logic             issue;
    logic             done_ok;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_tc;
    logic [7:0]       x_shadow;
    logic [7:0]       y_shadow;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        req         = txn_for_state(state, FILTER_CFG);
        issue       = is_txn_state(state) && !txn_out && !TXN_BUSY;
        done_ok     = txn_out && TXN_DONE;
        timer_load  = 1'b0;
        timer_value = TIMEOUT_LOAD;
        if (issue) begin
            timer_load = 1'b1;
        end else if (done_ok) begin
            case (state)
                S_SOFTRST: begin
                    timer_load  = 1'b1;
                    timer_value = RSTWAIT_LOAD;
                end
                S_PWR, S_RDZ: begin
                    timer_load  = 1'b1;
                    timer_value = POLL_LOAD;
                end
                S_STAT: begin
                    timer_load  = !TXN_RDATA[0];
                    timer_value = POLL_LOAD;
                end
                default: ;
            endcase
        end
    end

    acl2_txn_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (timer_load),
        .load_value(timer_value),
        .tc        (timer_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_SOFTRST;
            txn_out      <= 1'b0;
            TXN_START    <= 1'b0;
            TXN_RW       <= 1'b0;
            TXN_ADDR     <= 8'h00;
            TXN_WDATA    <= 8'h00;
            x_shadow     <= 8'h00;
            y_shadow     <= 8'h00;
            X_DATA       <= 8'h00;
            Y_DATA       <= 8'h00;
            Z_DATA       <= 8'h00;
            SAMPLE_VALID <= 1'b0;
            INIT_DONE    <= 1'b0;
            FAULT        <= FAULT_NONE;
        end else begin
            TXN_START    <= 1'b0;
            SAMPLE_VALID <= 1'b0;
            case (state)
                S_RSTWAIT:  if (timer_tc) state <= S_IDRD;
                S_POLLWAIT: if (timer_tc) state <= S_STAT;
                S_FAULT:    ;
                default: begin
                    if (issue) begin
                        TXN_START <= 1'b1;
                        TXN_RW    <= (req.cmd == CMD_WRITE);
                        TXN_ADDR  <= req.addr;
                        TXN_WDATA <= req.wdata;
                        txn_out   <= 1'b1;
                    end else if (done_ok) begin
                        txn_out <= 1'b0;
                        case (state)
                            S_SOFTRST: state <= S_RSTWAIT;
                            S_IDRD: begin
                                if (TXN_RDATA == ID_EXPECT) begin
                                    state <= S_FILT;
                                end else begin
                                    FAULT <= FAULT_DEVID;
                                    state <= S_FAULT;
                                end
                            end
                            S_FILT: state <= S_PWR;
                            S_PWR: begin
                                INIT_DONE <= 1'b1;
                                state     <= S_POLLWAIT;
                            end
                            S_STAT: state <= TXN_RDATA[0] ? S_RDX : S_POLLWAIT;
                            S_RDX: begin
                                x_shadow <= TXN_RDATA;
                                state    <= S_RDY;
                            end
                            S_RDY: begin
                                y_shadow <= TXN_RDATA;
                                state    <= S_RDZ;
                            end
                            S_RDZ: begin
                                // All three axes change on this one edge, never piecemeal.
                                X_DATA       <= x_shadow;
                                Y_DATA       <= y_shadow;
                                Z_DATA       <= TXN_RDATA;
                                SAMPLE_VALID <= 1'b1;
                                state        <= S_POLLWAIT;
                            end
                            default: ;
                        endcase
                    end else if (txn_out && timer_tc) begin
                        txn_out <= 1'b0;
                        FAULT   <= FAULT_TIMEOUT;
                        state   <= S_FAULT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acl2_sequencer.sv
// Bench for acl2_sequencer: an SPI-engine model answers register reads from
// per-run tables, and the checks compare against sequences derived from the register protocol.
module tb_acl2_sequencer;

    localparam int POLL = 20;
    localparam int RWAIT = 10;
    localparam int TOUT = 100;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TXN_START;
    logic       TXN_RW;
    logic [7:0] TXN_ADDR;
    logic [7:0] TXN_WDATA;
    logic       TXN_BUSY = 1'b0;
    logic       TXN_DONE = 1'b0;
    logic [7:0] TXN_RDATA = 8'h00;
    logic [7:0] X_DATA;
    logic [7:0] Y_DATA;
    logic [7:0] Z_DATA;
    logic       SAMPLE_VALID;
    logic       INIT_DONE;
    logic [1:0] FAULT;

    acl2_sequencer #(
        .POLL_DIVIDE(POLL),
        .RESET_WAIT (RWAIT),
        .TIMEOUT    (TOUT),
        .ID_EXPECT  (8'hAD),
        .FILTER_CFG (8'h13)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .TXN_START   (TXN_START),
        .TXN_RW      (TXN_RW),
        .TXN_ADDR    (TXN_ADDR),
        .TXN_WDATA   (TXN_WDATA),
        .TXN_BUSY    (TXN_BUSY),
        .TXN_DONE    (TXN_DONE),
        .TXN_RDATA   (TXN_RDATA),
        .X_DATA      (X_DATA),
        .Y_DATA      (Y_DATA),
        .Z_DATA      (Z_DATA),
        .SAMPLE_VALID(SAMPLE_VALID),
        .INIT_DONE   (INIT_DONE),
        .FAULT       (FAULT)
    );

    initial forever #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         start_cyc;
        int         done_cyc;
    } txn_t;

    txn_t        log_q[$];
    logic [7:0]  devid = 8'hAD;
    bit          withhold_y = 1'b0;
    int          spurious_at = -1;
    logic [7:0]  status_seq[64];
    logic [23:0] xyz_seq[64];

    logic [23:0] smp_q[$];
    int          smp_cyc_q[$];
    int          init_rise = -1;
    int          fault_seen = -1;
    logic        init_prev = 1'b0;
    logic [1:0]  fault_prev = 2'b00;

    int n_checks = 0;
    int n_fail = 0;

    // SPI engine model: everything happens on the falling edge, away from the DUT's edge.
    int   bfm_lat = 0;
    int   bfm_busy_hold = 0;
    int   bfm_st_idx = 0;
    int   bfm_smp_idx = 0;
    bit   bfm_pending = 1'b0;
    bit   bfm_arm = 1'b0;
    bit   bfm_stuck = 1'b0;
    txn_t bfm_t;

    initial begin
        forever begin
            @(negedge CLK);
            TXN_DONE = 1'b0;
            if (bfm_busy_hold > 0) bfm_busy_hold--;
            if (bfm_arm) begin
                bfm_busy_hold = 5;
                bfm_arm = 1'b0;
            end
            if (RST) begin
                bfm_pending = 1'b0;
                bfm_stuck = 1'b0;
                bfm_busy_hold = 0;
                bfm_arm = 1'b0;
                bfm_st_idx = 0;
                bfm_smp_idx = 0;
            end else begin
                if (bfm_pending && !bfm_stuck) begin
                    if (bfm_lat == 0) begin
                        bfm_t = log_q[log_q.size()-1];
                        log_q[log_q.size()-1].done_cyc = cyc;
                        TXN_DONE = 1'b1;
                        bfm_pending = 1'b0;
                        if (bfm_t.rw) begin
                            TXN_RDATA = 8'($urandom);
                        end else begin
                            case (bfm_t.addr)
                                8'h00: TXN_RDATA = devid;
                                8'h0B: begin
                                    TXN_RDATA = status_seq[bfm_st_idx % 64];
                                    bfm_st_idx++;
                                end
                                8'h08: TXN_RDATA = xyz_seq[bfm_smp_idx % 64][23:16];
                                8'h09: TXN_RDATA = xyz_seq[bfm_smp_idx % 64][15:8];
                                8'h0A: begin
                                    TXN_RDATA = xyz_seq[bfm_smp_idx % 64][7:0];
                                    bfm_smp_idx++;
                                end
                                default: TXN_RDATA = 8'($urandom);
                            endcase
                            if (bfm_t.addr == 8'h00) bfm_arm = 1'b1;
                        end
                    end else begin
                        bfm_lat--;
                    end
                end else if (!bfm_pending && cyc == spurious_at) begin
                    TXN_DONE = 1'b1;
                    TXN_RDATA = 8'hFF;
                end
                if (TXN_START) begin
                    log_q.push_back('{rw: TXN_RW, addr: TXN_ADDR, wdata: TXN_WDATA,
                                      start_cyc: cyc, done_cyc: -1});
                    bfm_pending = 1'b1;
                    bfm_lat = int'($urandom_range(3, 0));
                    bfm_stuck = withhold_y && !TXN_RW && (TXN_ADDR == 8'h09);
                end
            end
            TXN_BUSY = bfm_pending || (bfm_busy_hold > 0);
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (SAMPLE_VALID) begin
                smp_q.push_back({X_DATA, Y_DATA, Z_DATA});
                smp_cyc_q.push_back(cyc);
            end
            if (INIT_DONE && !init_prev) init_rise = cyc;
            init_prev = INIT_DONE;
            if (FAULT != 2'b00 && fault_prev == 2'b00) fault_seen = cyc;
            fault_prev = FAULT;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reads compare as {rw, addr, 00}; writes include their data byte.
    function automatic logic [16:0] ent(input int k);
        if (k < 0 || k >= log_q.size()) return 17'h1FFFF;
        return {log_q[k].rw, log_q[k].addr, log_q[k].rw ? log_q[k].wdata : 8'h00};
    endfunction

    function automatic int count_addr(input int from, input logic [7:0] a, input logic rw);
        int c = 0;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].addr == a && log_q[i].rw == rw) c++;
        return c;
    endfunction

    function automatic int cyc_of(input int k, input bit done);
        if (k < 0 || k >= log_q.size()) return -1000;
        return done ? log_q[k].done_cyc : log_q[k].start_cyc;
    endfunction

    logic [16:0] bringup[4];
    logic [45:0] all_out;
    int base;
    int gap_min;
    int ready;
    int stat_expect;

    always_comb all_out = {TXN_START, TXN_RW, TXN_ADDR, TXN_WDATA, X_DATA, Y_DATA, Z_DATA,
                           SAMPLE_VALID, INIT_DONE, FAULT};

    initial begin
        bringup[0] = {1'b1, 8'h1F, 8'h52};
        bringup[1] = {1'b0, 8'h00, 8'h00};
        bringup[2] = {1'b1, 8'h2C, 8'h13};
        bringup[3] = {1'b1, 8'h2D, 8'h02};
        for (int i = 0; i < 64; i++) begin
            status_seq[i] = 8'($urandom);
            if (i % 5 == 4) status_seq[i][0] = 1'b1;
            xyz_seq[i] = 24'($urandom);
        end
        status_seq[0] = 8'h00;
        status_seq[1] = 8'h00;
        status_seq[2] = 8'h00;
        status_seq[3] = 8'h01;
        xyz_seq[0] = 24'h12F07F;

        // Reset state
        RST = 1'b1;
        step(3);
        check("reset_outputs", 64'(all_out), 64'd0);
        check("reset_no_txn", log_q.size(), 0);
        RST = 1'b0;

        // Bring-up, BUSY stall before FILTER_CTL, three not-ready polls, one sample
        for (int i = 0; i < 3000 && smp_q.size() < 1; i++) step(1);
        check("p1_sample_count", smp_q.size(), 1);
        check("p1_log_len", log_q.size(), 11);
        for (int k = 0; k < 4; k++) check($sformatf("bringup_txn%0d", k), ent(k), bringup[k]);
        check("p1_init_done", INIT_DONE, 1'b1);
        check("p1_fault", FAULT, 2'b00);
        check("init_latency", init_rise - cyc_of(3, 1), 1);
        check("filt_busy_delay", cyc_of(2, 0) - cyc_of(1, 1), 7);
        check("filt_single", count_addr(0, 8'h2C, 1'b1), 1);
        gap_min = 1000000;
        for (int k = 4; k < 8; k++) begin
            check($sformatf("status_rd%0d", k - 4), ent(k), {1'b0, 8'h0B, 8'h00});
            if (k > 4 && (cyc_of(k, 0) - cyc_of(k - 1, 0)) < gap_min)
                gap_min = cyc_of(k, 0) - cyc_of(k - 1, 0);
        end
        check("status_spacing", gap_min >= POLL, 1'b1);
        check("rd_x", ent(8), {1'b0, 8'h08, 8'h00});
        check("rd_y", ent(9), {1'b0, 8'h09, 8'h00});
        check("rd_z", ent(10), {1'b0, 8'h0A, 8'h00});
        check("p1_sample_value", (smp_q.size() > 0) ? smp_q[0] : 24'hx, 24'h12F07F);
        check("p1_outputs", {X_DATA, Y_DATA, Z_DATA}, 24'h12F07F);
        check("sample_latency", ((smp_cyc_q.size() > 0) ? smp_cyc_q[0] : -1) - cyc_of(10, 1), 1);

        // Stray DONE while waiting to poll must be ignored
        base = log_q.size();
        spurious_at = cyc + 3;
        step(8);
        check("spurious_no_txn", log_q.size(), base);
        check("spurious_no_sample", smp_q.size(), 1);

        // Randomized STATUS/XYZ: the fifth sample arrives after the fifth ready STATUS
        ready = 0;
        stat_expect = -1;
        for (int i = 0; i < 64; i++) begin
            if (status_seq[i][0]) begin
                ready++;
                if (ready == 5 && stat_expect < 0) stat_expect = i + 1;
            end
        end
        for (int i = 0; i < 8000 && smp_q.size() < 5; i++) step(1);
        check("rand_sample_count", smp_q.size(), 5);
        for (int k = 1; k < 5; k++)
            check($sformatf("rand_sample%0d", k), (k < smp_q.size()) ? smp_q[k] : 24'hx, xyz_seq[k]);
        check("rand_status_reads", count_addr(0, 8'h0B, 1'b0), stat_expect);
        check("rand_outputs", {X_DATA, Y_DATA, Z_DATA}, xyz_seq[4]);

        // Withheld DONE on the Y read -> timeout fault, sample held
        withhold_y = 1'b1;
        for (int i = 0; i < 3000 && FAULT == 2'b00; i++) step(1);
        check("timeout_code", FAULT, 2'b10);
        check("timeout_on_y", ent(log_q.size() - 1), {1'b0, 8'h09, 8'h00});
        check("timeout_latency", fault_seen - cyc_of(log_q.size() - 1, 0), TOUT);
        check("timeout_hold_xyz", {X_DATA, Y_DATA, Z_DATA}, xyz_seq[4]);
        base = log_q.size();
        step(200);
        check("fault_no_txn", log_q.size(), base);
        check("fault_hold_init", INIT_DONE, 1'b1);
        check("fault_no_sample", smp_q.size(), 5);

        // Reset recovery, then RST during the Y read
        withhold_y = 1'b0;
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        for (int i = 0; i < 3000 && smp_q.size() < 6; i++) step(1);
        check("recover_sample", (smp_q.size() > 5) ? smp_q[5] : 24'hx, xyz_seq[0]);
        for (int i = 0; i < 3000 && !(log_q.size() > 0 && log_q[log_q.size()-1].addr == 8'h09); i++)
            step(1);
        check("rdy_reached", ent(log_q.size() - 1), {1'b0, 8'h09, 8'h00});
        RST = 1'b1;
        step(1);
        check("midtxn_reset_outputs", 64'(all_out), 64'd0);
        RST = 1'b0;
        base = log_q.size();
        for (int i = 0; i < 500 && log_q.size() <= base; i++) step(1);
        check("after_reset_first_txn", ent(base), {1'b1, 8'h1F, 8'h52});

        // Wrong DEVID -> terminal fault
        devid = 8'hAB;
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        base = log_q.size();
        for (int i = 0; i < 500 && FAULT == 2'b00; i++) step(1);
        check("devid_fault", FAULT, 2'b01);
        check("devid_init_done", INIT_DONE, 1'b0);
        check("devid_txn_count", log_q.size() - base, 2);
        check("devid_idrd", ent(base + 1), {1'b0, 8'h00, 8'h00});
        base = log_q.size();
        step(1000);
        check("devid_no_txn", log_q.size(), base);
        check("devid_fault_hold", FAULT, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
